// File: rtl/video_fetch_controller_if.sv
// Video fetch bus bundle: the read-only video memory port plus the pixel
// stream towards the raster logic.
//   video_address : controller -> memory, registered byte read address
//   video_data    : memory -> controller, valid the cycle after its address
//   pixel_data    : controller -> consumer, FIFO head word (0 when empty)
//   pixel_valid   : controller -> consumer, FIFO not empty
//   pixel_ready   : consumer -> controller, word accepted when valid & ready
interface video_fetch_controller_if #(
  parameter int ADDRESS_SIZE = 12
);
  logic [ADDRESS_SIZE-1:0] video_address;
  logic [31:0]             video_data;
  logic [31:0]             pixel_data;
  logic                    pixel_valid;
  logic                    pixel_ready;

  modport master (
    output video_address,
    input  video_data,
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  video_address,
    output video_data,
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

// File: rtl/video_fetch_controller.sv
// Video fetch controller: on each line_start, reads words_per_line 32-bit
// words from video memory at the running frame pointer into a small FIFO and
// streams them out over a valid/ready handshake.
//   clk, rst        : clock (also the memory video_clk), sync active-high reset
//   enable          : low = idle, FIFO flushed, fetch/frame/line requests ignored
//   frame_start     : reload pointer from base_address, abort line, clear flags
//   line_start      : begin fetching words_per_line words
//   base_address    : frame base byte address (low two bits ignored)
//   words_per_line  : line length in words, sampled on line_start
//   busy            : fetching, or a read is still in flight
//   underrun        : sticky, consumer ready while FIFO empty during a fetch
//   line_overrun    : sticky, line_start arrived while still fetching
//   vif (master)    : video memory read port and pixel stream
//
// state | meaning
// IDLE  | no words left to issue for the current line
// FETCH | issuing reads, remaining holds words not yet issued
module video_fetch_controller #(
  parameter int ADDRESS_SIZE     = 12,
  parameter int FIFO_DEPTH       = 4,
  parameter int LINE_WORDS_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic [ADDRESS_SIZE-1:0]     base_address,
  input  logic [LINE_WORDS_WIDTH-1:0] words_per_line,
  output logic                        busy,
  output logic                        underrun,
  output logic                        line_overrun,
  video_fetch_controller_if.master    vif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t                      state, state_n;
  logic [LINE_WORDS_WIDTH-1:0] remaining, remaining_n;
  logic [ADDRESS_SIZE-1:0]     pointer, pointer_base;
  logic                        issue_q, capture_q;
  logic [31:0]                 fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic [CW-1:0]               count, count_n;
  logic [SW-1:0]               pending_n;
  logic                        flush, push, pop, restart, issue_n, capture_n;

  assign vif.pixel_valid = (count != '0);
  assign vif.pixel_data  = vif.pixel_valid ? fifo_mem[rd_ptr] : '0;

  // issue_q marks a cycle whose video_address is a live read; capture_q marks
  // the following cycle, when that read's data is on video_data. The issue
  // decision for the next cycle is made here so the address can be registered.
  always_comb begin
    flush        = !enable || frame_start;
    restart      = enable && frame_start;
    push         = capture_q;
    pop          = vif.pixel_valid && vif.pixel_ready;
    pointer_base = restart ? (base_address & ~ADDRESS_SIZE'(3)) : pointer;

    state_n     = state;
    remaining_n = remaining;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      if (frame_start) begin
        state_n = IDLE;
      end else if (state == FETCH && issue_q) begin
        remaining_n = remaining - LINE_WORDS_WIDTH'(1);
        if (remaining == LINE_WORDS_WIDTH'(1)) state_n = IDLE;
      end
      // frame_start aborts the old line, so a coincident line_start is accepted
      if (line_start && words_per_line != '0 && (state == IDLE || frame_start)) begin
        state_n     = FETCH;
        remaining_n = words_per_line;
      end
    end

    count_n   = flush ? '0 : count + CW'(push) - CW'(pop);
    capture_n = flush ? 1'b0 : issue_q;
    // occupancy plus outstanding read as seen in the cycle being decided
    pending_n = SW'(count_n) + SW'(capture_n);
    issue_n   = enable && (state_n == FETCH) && (pending_n < SW'(FIFO_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      remaining         <= '0;
      pointer           <= '0;
      vif.video_address <= '0;
      issue_q           <= 1'b0;
      capture_q         <= 1'b0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      busy              <= 1'b0;
      underrun          <= 1'b0;
      line_overrun      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      issue_q   <= issue_n;
      capture_q <= capture_n;
      count     <= count_n;
      busy      <= (state_n == FETCH) || capture_n;

      if (issue_n) begin
        vif.video_address <= pointer_base;
        pointer           <= pointer_base + ADDRESS_SIZE'(4);
      end else begin
        pointer <= pointer_base;
      end

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
      end

      if (enable) begin
        if (frame_start) begin
          underrun     <= 1'b0;
          line_overrun <= 1'b0;
        end else begin
          if (vif.pixel_ready && !vif.pixel_valid && busy) underrun <= 1'b1;
          if (line_start && state == FETCH) line_overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) fifo_mem[wr_ptr] <= vif.video_data;
  end
endmodule
